div_unit: RTL and testbench

- Multi-cycle 32-bit integer divider for DIV/DIVU.
- Instantiated beside the execute stage. Its 64-bit result becomes the execute stage's HI/LO write data, which is then registered into the EX/MEM pipeline register.
- While a division is in progress, the execute stage holds the pipeline by asserting its stall request until ready_o rises.
- Uses restoring shift-subtract, one quotient bit per clock.

---
 rtl/div_unit.sv | 141 ++++++++++++++
 tb/tb_div_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring shift-subtract divider for DIV/DIVU.
// Result {remainder, quotient} feeds the execute stage HI/LO write data.
module div_unit #(
    parameter int DATA_W = 32,
    parameter int ITER   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o
);

    localparam int            CW       = $clog2(ITER + 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(ITER);

    localparam logic [1:0] S_FREE   = 2'd0;
    localparam logic [1:0] S_BYZERO = 2'd1;
    localparam logic [1:0] S_ON     = 2'd2;
    localparam logic [1:0] S_END    = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*DATA_W:0]   work_q, work_d;
    logic [DATA_W-1:0]   dvsr_q, dvsr_d;
    logic                qneg_q, qneg_d;
    logic                rneg_q, rneg_d;
    logic [2*DATA_W-1:0] result_q, result_d;
    logic                ready_q, ready_d;

    logic                op1_neg, op2_neg;
    logic [DATA_W-1:0]   op1_abs, op2_abs;
    logic [DATA_W-1:0]   quot, rem;
    logic [DATA_W:0]     trial;

    always_comb begin
        op1_neg = signed_div_i & opdata1_i[DATA_W-1];
        op2_neg = signed_div_i & opdata2_i[DATA_W-1];
        op1_abs = op1_neg ? -opdata1_i : opdata1_i;
        op2_abs = op2_neg ? -opdata2_i : opdata2_i;
        trial   = work_q[2*DATA_W:DATA_W] - {1'b0, dvsr_q};
        // Sign fix-up wraps, so 0x80000000 / -1 stays 0x80000000
        quot    = work_q[DATA_W-1:0];
        rem     = work_q[2*DATA_W:DATA_W+1];
        if (qneg_q) quot = -quot;
        if (rneg_q) rem = -rem;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        dvsr_d   = dvsr_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        ready_d  = ready_q;
        case (state_q)
            S_FREE: begin
                result_d = '0;
                ready_d  = 1'b0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = S_BYZERO;
                    end else begin
                        state_d = S_ON;
                        cnt_d   = '0;
                        work_d  = {{DATA_W{1'b0}}, op1_abs, 1'b0};
                        dvsr_d  = op2_abs;
                        qneg_d  = op1_neg ^ op2_neg;
                        rneg_d  = op1_neg;
                    end
                end
            end
            S_BYZERO: begin
                state_d  = S_END;
                result_d = '0;
                ready_d  = 1'b0;
            end
            S_ON: begin
                if (annul_i) begin
                    state_d  = S_FREE;
                    cnt_d    = '0;
                    result_d = '0;
                    ready_d  = 1'b0;
                end else if (cnt_q != CNT_DONE) begin
                    if (trial[DATA_W]) begin
                        work_d = {work_q[2*DATA_W-1:0], 1'b0};
                    end else begin
                        work_d = {trial[DATA_W-1:0],
                                  work_q[DATA_W-1:0], 1'b1};
                    end
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    state_d  = S_END;
                    cnt_d    = '0;
                    result_d = {rem, quot};
                    ready_d  = 1'b1;
                end
            end
            default: begin
                ready_d = 1'b1;
                if (!start_i) begin
                    state_d  = S_FREE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FREE;
            cnt_q    <= '0;
            work_q   <= '0;
            dvsr_q   <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            dvsr_q   <= dvsr_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed and random DIV/DIVU checks of div_unit
// against a plain-arithmetic reference model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;

    int n_cmp = 0;
    int n_err = 0;

    div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_div(input bit s,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint q;
        longint r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
        end else begin
            q = longint'({32'd0, a}) / longint'({32'd0, b});
            r = longint'({32'd0, a}) % longint'({32'd0, b});
        end
        return {r[31:0], q[31:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full handshake: start held until ready, one hold cycle, then drop.
    task automatic do_div(input string tag, input bit s,
                          input logic [31:0] a, input logic [31:0] b);
        int          lat;
        int          want_lat;
        logic [63:0] exp;
        exp          = ref_div(s, a, b);
        want_lat     = (b == 32'd0) ? 2 : 33;
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        annul_i      = 1'b0;
        start_i      = 1'b1;
        tick();
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        lat = 0;
        while (!ready_o && lat < 40) begin
            tick();
            lat++;
        end
        chk({tag, ".lat"}, 64'(lat), 64'(want_lat));
        chk({tag, ".res"}, result_o, exp);
        annul_i = 1'($urandom_range(0, 1));
        tick();
        chk({tag, ".hold"}, {result_o[62:0], ready_o}, {exp[62:0], 1'b1});
        annul_i = 1'b0;
        start_i = 1'b0;
        tick();
        chk({tag, ".drop"}, {result_o[62:0], ready_o}, 64'd0);
    endtask

    // Counts ready_o highs over n edges; nothing should come out.
    task automatic quiet(input string tag, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (ready_o) seen++;
        end
        chk(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        bit          s;

        tick();
        tick();
        chk("reset", {result_o[62:0], ready_o}, 64'd0);
        rst = 1'b0;
        tick();

        do_div("divu_100_7", 1'b0, 32'd100, 32'd7);
        do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
        do_div("divu_max_2", 1'b0, 32'hFFFF_FFFF, 32'd2);
        do_div("div_by0", 1'b1, 32'h1234_5678, 32'd0);
        do_div("divu_by0", 1'b0, 32'hDEAD_BEEF, 32'd0);
        do_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        do_div("divu_3_5", 1'b0, 32'd3, 32'd5);

        // Annul at iteration 10
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        repeat (10) tick();
        annul_i = 1'b1;
        start_i = 1'b0;
        tick();
        annul_i = 1'b0;
        chk("annul.out", {result_o[62:0], ready_o}, 64'd0);
        quiet("annul.quiet", 40);
        do_div("after_annul", 1'b0, 32'd9, 32'd3);

        // Reset at iteration 20
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        repeat (20) tick();
        rst     = 1'b1;
        start_i = 1'b0;
        tick();
        chk("rst_mid.out", {result_o[62:0], ready_o}, 64'd0);
        rst = 1'b0;
        quiet("rst_mid.quiet", 40);

        // Annul on the same edge as the final step
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        repeat (33) tick();
        annul_i = 1'b1;
        start_i = 1'b0;
        tick();
        annul_i = 1'b0;
        quiet("annul_last.quiet", 40);

        // annul with start in FREE must not start anything
        opdata1_i = 32'd50;
        opdata2_i = 32'd5;
        start_i   = 1'b1;
        annul_i   = 1'b1;
        repeat (3) tick();
        chk("annul_start", {result_o[62:0], ready_o}, 64'd0);
        do_div("after_blk", 1'b0, 32'd50, 32'd5);

        for (int i = 0; i < 30; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 20));
                2: b = -32'($urandom_range(1, 20));
                3: a = 32'($urandom_range(0, 50));
                default: ;
            endcase
            do_div($sformatf("rnd%0d", i), s, a, b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
